// File: rtl/circ_ref_buffer.sv
// Circular I/Q reference buffer: load DEPTH samples, then serve indexed bursts
// through a two-stage (memory read + output register) pipeline. Define CIRC_REF_BUFFER_WRAP_EN for wrap-around reads.
module circ_ref_buffer #(
    parameter int I_BITS     = 12,
    parameter int Q_BITS     = 12,
    parameter int DEPTH      = 64,
    parameter int INDEX_BITS = $clog2(DEPTH),
    parameter int LEN_BITS   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    input  logic signed [I_BITS-1:0]     s_axi_wi,
    input  logic signed [Q_BITS-1:0]     s_axi_wq,
    output logic                         load_done,
    input  logic                         reload,
    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready,
    input  logic        [INDEX_BITS-1:0] m_axi_index_rdata,
    input  logic        [LEN_BITS-1:0]   m_axi_len_rdata,
    output logic                         s_axi_data_rvalid,
    input  logic                         s_axi_data_rready,
    output logic signed [I_BITS-1:0]     i,
    output logic signed [Q_BITS-1:0]     q
);

    typedef enum logic [1:0] {LOAD, IDLE, STREAM} state_t;

    localparam int                    W         = I_BITS + Q_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_ADDR = INDEX_BITS'(DEPTH - 1);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_data_q;

    state_t                    state_q, state_d;
    logic [INDEX_BITS-1:0]     wptr_q, wptr_d;
    logic [INDEX_BITS-1:0]     raddr_q, raddr_d;
    logic [LEN_BITS-1:0]       remain_q, remain_d;
    logic                      issuing_q, issuing_d;
    logic                      load_done_q, load_done_d;
    logic                      wready_q, wready_d;
    logic                      mready_q, mready_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      rd_last_q, rd_last_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic signed [I_BITS-1:0]  i_q, i_d;
    logic signed [Q_BITS-1:0]  q_q, q_d;

    logic mem_we, out_adv, rd_adv, issue, issue_last;

    assign mem_we = !reset && (state_q == LOAD) && s_axi_wvalid;

    // Each stage advances when the stage after it is empty or draining,
    // so a stall holds both stages without dropping or repeating a sample.
    assign out_adv = !out_valid_q || s_axi_data_rready;
    assign rd_adv  = !rd_valid_q || out_adv;
    assign issue   = (state_q == STREAM) && issuing_q && rd_adv;

`ifdef CIRC_REF_BUFFER_WRAP_EN
    assign issue_last = (remain_q == '0);
`else
    assign issue_last = (remain_q == '0) || (raddr_q == LAST_ADDR);
`endif

    // NOTE: the sample memory has no reset so it maps onto block RAM; contents
    // survive reset, and the FSM forces a full reload before they are read.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wptr_q] <= {s_axi_wi, s_axi_wq};
        if (issue)
            rd_data_q <= mem[raddr_q];
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        state_d     = state_q;
        wptr_d      = wptr_q;
        load_done_d = load_done_q;
        raddr_d     = raddr_q;
        remain_d    = remain_q;
        issuing_d   = issuing_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        i_d         = i_q;
        q_d         = q_q;

        case (state_q)
            LOAD: begin
                if (s_axi_wvalid) begin
                    if (wptr_q == LAST_ADDR) begin
                        wptr_d      = '0;
                        state_d     = IDLE;
                        load_done_d = 1'b1;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end
            IDLE: begin
                if (reload) begin
                    state_d     = LOAD;
                    wptr_d      = '0;
                    load_done_d = 1'b0;
                end else if (m_axi_rvalid) begin
                    state_d   = STREAM;
                    raddr_d   = m_axi_index_rdata;
                    remain_d  = m_axi_len_rdata;
                    issuing_d = 1'b1;
                end
            end
            STREAM: begin
                if (out_valid_q && s_axi_data_rready && out_last_q)
                    state_d = IDLE;
            end
            default: state_d = LOAD;
        endcase

        if (issue) begin
            raddr_d   = (raddr_q == LAST_ADDR) ? '0 : raddr_q + 1'b1;
            remain_d  = remain_q - 1'b1;
            issuing_d = !issue_last;
        end

        if (rd_adv) begin
            rd_valid_d = issue;
            rd_last_d  = issue_last;
        end

        if (out_adv) begin
            out_valid_d = rd_valid_q;
            out_last_d  = rd_last_q;
            if (rd_valid_q) begin
                i_d = $signed(rd_data_q[W-1:Q_BITS]);
                q_d = $signed(rd_data_q[Q_BITS-1:0]);
            end
        end
    end

    assign wready_d = (state_d == LOAD);
    assign mready_d = (state_d == IDLE);

    // NOTE: all state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            wptr_q      <= '0;
            load_done_q <= 1'b0;
            wready_q    <= 1'b1;
            mready_q    <= 1'b0;
            raddr_q     <= '0;
            remain_q    <= '0;
            issuing_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            i_q         <= '0;
            q_q         <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            load_done_q <= load_done_d;
            wready_q    <= wready_d;
            mready_q    <= mready_d;
            raddr_q     <= raddr_d;
            remain_q    <= remain_d;
            issuing_q   <= issuing_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            i_q         <= i_d;
            q_q         <= q_d;
        end
    end

    assign s_axi_wready      = wready_q;
    assign load_done         = load_done_q;
    assign m_axi_rready      = mready_q;
    assign s_axi_data_rvalid = out_valid_q;
    assign i                 = i_q;
    assign q                 = q_q;

endmodule

// File: tb/tb_circ_ref_buffer.sv
// Self-checking bench for circ_ref_buffer: table of burst requests checked
// against a memory model through a scoreboard queue, plus reset/reload sequences.
module tb_circ_ref_buffer;

    localparam int IB    = 12;
    localparam int QB    = 12;
    localparam int DEPTH = 64;
    localparam int IXB   = 6;
    localparam int LB    = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic signed [IB-1:0]  s_axi_wi;
    logic signed [QB-1:0]  s_axi_wq;
    logic                  load_done;
    logic                  reload;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [IXB-1:0]        m_axi_index_rdata;
    logic [LB-1:0]         m_axi_len_rdata;
    logic                  s_axi_data_rvalid;
    logic                  s_axi_data_rready;
    logic signed [IB-1:0]  i;
    logic signed [QB-1:0]  q;

    circ_ref_buffer #(
        .I_BITS(IB), .Q_BITS(QB), .DEPTH(DEPTH), .INDEX_BITS(IXB), .LEN_BITS(LB)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wi(s_axi_wi), .s_axi_wq(s_axi_wq),
        .load_done(load_done), .reload(reload),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_index_rdata(m_axi_index_rdata), .m_axi_len_rdata(m_axi_len_rdata),
        .s_axi_data_rvalid(s_axi_data_rvalid), .s_axi_data_rready(s_axi_data_rready),
        .i(i), .q(q)
    );

    always #5 clk = ~clk;

    typedef struct { int i; int q; } samp_t;
    typedef struct { int index; int len; int mode; int exp_count; } vec_t;

    int    chk_cnt  = 0;
    int    pass_cnt = 0;
    int    mi [DEPTH];
    int    mq [DEPTH];
    samp_t sb [$];
    vec_t  vecs [6];

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int burst_count(input int index, input int len);
`ifdef CIRC_REF_BUFFER_WRAP_EN
        return len + 1;
`else
        return (len + 1 < DEPTH - index) ? len + 1 : DEPTH - index;
`endif
    endfunction

    task automatic load_buf(input int pattern);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            if (k == 0) check("load_wready", s_axi_wready, 1);
            if (k == 5) begin
                s_axi_wvalid = 1'b0;
                @(negedge clk);
            end
            if (k == DEPTH - 1) check("load_done_early", load_done, 0);
            case (pattern)
                0:       begin mi[k] = k;         mq[k] = -k;    end
                1:       begin mi[k] = 3 * k + 1; mq[k] = 7 - k; end
                default: begin mi[k] = -2 * k;    mq[k] = 5 * k; end
            endcase
            s_axi_wvalid = 1'b1;
            s_axi_wi     = IB'(mi[k]);
            s_axi_wq     = QB'(mq[k]);
        end
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        check("load_done", load_done, 1);
        check("load_wready_off", s_axi_wready, 0);
        check("idle_rready", m_axi_rready, 1);
    endtask

    // mode: 0 = ready always, 1 = toggle 1,0,..., 2 = random.
    // abort_at > 0 asserts reset on that output cycle instead of finishing.
    task automatic run_burst(input int index, input int len, input int mode,
                             input int expc, input int abort_at);
        int n = 0, got = 0, first = -1, last_n = 0;
        int gaps_ok = 1, stalled = 0, held_i = 0, held_q = 0;
        bit tog = 1'b1;
        bit rdy;
        samp_t e;
        @(negedge clk);
        check("req_rready", m_axi_rready, 1);
        m_axi_rvalid      = 1'b1;
        m_axi_index_rdata = IXB'(index);
        m_axi_len_rdata   = LB'(len);
        for (int a = 0; a < expc; a++)
            sb.push_back('{mi[(index + a) % DEPTH], mq[(index + a) % DEPTH]});
        while (sb.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
            m_axi_rvalid = 1'b0;
            reload = (n == 4 && expc > 4);
            if (stalled != 0) begin
                check("hold_valid", s_axi_data_rvalid, 1);
                check("hold_i", i, held_i);
                check("hold_q", q, held_q);
            end
            stalled = 0;
            if (s_axi_data_rvalid) begin
                if (first < 0) first = n;
                if (abort_at > 0 && got == abort_at - 1) begin
                    reset = 1'b1;
                    s_axi_data_rready = 1'b1;
                    @(negedge clk);
                    reset  = 1'b0;
                    reload = 1'b0;
                    check("abort_rvalid", s_axi_data_rvalid, 0);
                    check("abort_wready", s_axi_wready, 1);
                    check("abort_load_done", load_done, 0);
                    check("abort_rready", m_axi_rready, 0);
                    check("abort_i", i, 0);
                    repeat (4) @(negedge clk);
                    check("abort_quiet", s_axi_data_rvalid, 0);
                    sb.delete();
                    return;
                end
                rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
                tog = ~tog;
                s_axi_data_rready = rdy;
                if (rdy) begin
                    if (mode == 0 && got > 0 && n != last_n + 1) gaps_ok = 0;
                    last_n = n;
                    e = sb.pop_front();
                    check("sample_i", i, e.i);
                    check("sample_q", q, e.q);
                    got++;
                end else begin
                    stalled = 1;
                    held_i  = i;
                    held_q  = q;
                end
            end else begin
                s_axi_data_rready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        reload = 1'b0;
        if (sb.size() > 0) begin
            check("burst_timeout", sb.size(), 0);
            sb.delete();
        end
        check("first_latency", first, 3);
        if (mode == 0) check("back_to_back", gaps_ok, 1);
        @(negedge clk);
        check("no_extra_rvalid", s_axi_data_rvalid, 0);
        check("back_idle", m_axi_rready, 1);
        check("load_done_kept", load_done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int saw;
        vecs[0] = '{0,  63,  0, burst_count(0, 63)};
        vecs[1] = '{10, 3,   1, burst_count(10, 3)};
        vecs[2] = '{62, 3,   0, burst_count(62, 3)};
        vecs[3] = '{63, 0,   2, burst_count(63, 0)};
        vecs[4] = '{60, 255, 2, burst_count(60, 255)};
        vecs[5] = '{33, 20,  2, burst_count(33, 20)};

        reset = 1'b1; s_axi_wvalid = 1'b0; s_axi_wi = '0; s_axi_wq = '0;
        reload = 1'b0; m_axi_rvalid = 1'b0; m_axi_index_rdata = '0;
        m_axi_len_rdata = '0; s_axi_data_rready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wready", s_axi_wready, 1);
        check("rst_load_done", load_done, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_rvalid", s_axi_data_rvalid, 0);
        check("rst_i", i, 0);
        check("rst_q", q, 0);
        reset = 1'b0;

        load_buf(0);
        foreach (vecs[v])
            run_burst(vecs[v].index, vecs[v].len, vecs[v].mode, vecs[v].exp_count, 0);

        run_burst(20, 15, 0, 16, 3);
        load_buf(1);
        run_burst(5, 7, 2, 8, 0);

        @(negedge clk);
        reload = 1'b1;
        m_axi_rvalid = 1'b1;
        m_axi_index_rdata = '0;
        m_axi_len_rdata = 8'd3;
        @(negedge clk);
        reload = 1'b0;
        m_axi_rvalid = 1'b0;
        check("reload_rready", m_axi_rready, 0);
        check("reload_wready", s_axi_wready, 1);
        check("reload_load_done", load_done, 0);
        saw = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_axi_data_rvalid) saw++;
        end
        check("reload_no_stream", saw, 0);

        load_buf(2);
        run_burst(0, 63, 0, 64, 0);
        run_burst(vecs[2].index, vecs[2].len, 1, vecs[2].exp_count, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
